// File: rtl/lane_merge_rx.sv
// Three-lane serial receiver: deserializes lanes A/B/C and merges their bytes, in lane order, into one addressed stream.
// Optional build macro RX_PARITY_EN adds a trailing even-parity bit per lane word and the sticky PAR_ERR flag.
module lane_merge_rx #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 10,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              CLK_48MHZ,
    input  logic              RSTN,
    input  logic              VALID,
    input  logic              DIN_A,
    input  logic              DIN_B,
    input  logic              DIN_C,
    input  logic [1:0]        MODE,
    input  logic              ERR_CLR,
    output logic [DATA_W-1:0] DATA,
    output logic [ADDR_W-1:0] ADDR,
    output logic              DATA_VALID,
    input  logic              DATA_READY,
    output logic              FRAME_ERR,
    output logic              OVF,
    output logic              PAR_ERR
);

`ifdef RX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int WORD_W = DATA_W + PAR_BITS;
    localparam int CNT_W  = $clog2(WORD_W);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int OCC_W  = PTR_W + 1;

    typedef enum logic [1:0] {D_IDLE, D_A, D_B, D_C} drain_state_t;

    logic              valid_q;
    logic [1:0]        mode_q;
    logic [1:0]        mode_eff;
    logic [1:0]        drain_mode;
    logic [CNT_W-1:0]  bitcnt;
    logic [WORD_W-2:0] sh_a, sh_b, sh_c;
    logic [WORD_W-1:0] word_a, word_b, word_c;
    logic [DATA_W-1:0] hold_a, hold_b, hold_c;
    logic              word_done;
    logic              frame_set;

    drain_state_t      state, state_next;
    logic              push;
    logic [DATA_W-1:0] push_data;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [OCC_W-1:0]  count;
    logic              full, pop, push_ok, ovf_set;
    logic              frame_q, ovf_q;

    // The first cycle of a frame uses MODE directly, since the latch only updates at that edge
    assign mode_eff  = (VALID && !valid_q) ? MODE : mode_q;
    assign word_a    = {sh_a, DIN_A};
    assign word_b    = {sh_b, DIN_B};
    assign word_c    = {sh_c, DIN_C};
    assign word_done = VALID && (bitcnt == CNT_W'(WORD_W - 1));
    assign frame_set = !VALID && (bitcnt != '0);

    always_ff @(posedge CLK_48MHZ or posedge RSTN) begin
        if (RSTN) begin
            valid_q    <= 1'b0;
            mode_q     <= 2'b10;
            drain_mode <= 2'b10;
            bitcnt     <= '0;
            sh_a       <= '0;
            sh_b       <= '0;
            sh_c       <= '0;
            hold_a     <= '0;
            hold_b     <= '0;
            hold_c     <= '0;
        end else begin
            valid_q <= VALID;
            if (VALID && !valid_q)
                mode_q <= MODE;
            if (VALID) begin
                sh_a <= word_a[WORD_W-2:0];
                sh_b <= word_b[WORD_W-2:0];
                sh_c <= word_c[WORD_W-2:0];
                if (word_done) begin
                    bitcnt     <= '0;
                    hold_a     <= word_a[WORD_W-1 -: DATA_W];
                    hold_b     <= word_b[WORD_W-1 -: DATA_W];
                    hold_c     <= word_c[WORD_W-1 -: DATA_W];
                    drain_mode <= mode_eff;
                end else begin
                    bitcnt <= bitcnt + CNT_W'(1);
                end
            end else begin
                bitcnt <= '0;
            end
        end
    end

    always_ff @(posedge CLK_48MHZ or posedge RSTN) begin
        if (RSTN)
            state <= D_IDLE;
        else
            state <= state_next;
    end

    // One hold byte per state; lanes outside the latched mode skip their state
    always_comb begin
        state_next = state;
        push       = 1'b0;
        push_data  = '0;
        case (state)
            D_IDLE: if (word_done) state_next = D_A;
            D_A: begin
                push       = 1'b1;
                push_data  = hold_a;
                state_next = (drain_mode == 2'b00) ? D_IDLE : D_B;
            end
            D_B: begin
                push       = 1'b1;
                push_data  = hold_b;
                state_next = drain_mode[1] ? D_C : D_IDLE;
            end
            D_C: begin
                push       = 1'b1;
                push_data  = hold_c;
                state_next = D_IDLE;
            end
            default: state_next = D_IDLE;
        endcase
    end

    assign DATA_VALID = (count != '0);
    assign full       = (count == OCC_W'(FIFO_DEPTH));
    assign pop        = DATA_VALID && DATA_READY;
    assign push_ok    = push && (!full || pop);
    assign ovf_set    = push && full && !pop;
    assign DATA       = DATA_VALID ? mem[rd_ptr] : '0;

    always_ff @(posedge CLK_48MHZ) begin
        if (push_ok)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge CLK_48MHZ or posedge RSTN) begin
        if (RSTN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ADDR   <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                ADDR   <= ADDR + ADDR_W'(1);
            end
            if (push_ok && !pop)
                count <= count + OCC_W'(1);
            else if (!push_ok && pop)
                count <= count - OCC_W'(1);
        end
    end

    // Sticky flags: a new event in the same cycle as ERR_CLR keeps the flag set
    always_ff @(posedge CLK_48MHZ or posedge RSTN) begin
        if (RSTN) begin
            frame_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            frame_q <= frame_set | (frame_q & ~ERR_CLR);
            ovf_q   <= ovf_set | (ovf_q & ~ERR_CLR);
        end
    end

    assign FRAME_ERR = frame_q;
    assign OVF       = ovf_q;

`ifdef RX_PARITY_EN
    logic par_set;
    logic par_q;

    assign par_set = word_done && ((^word_a) ||
                                   ((mode_eff != 2'b00) && (^word_b)) ||
                                   (mode_eff[1] && (^word_c)));

    always_ff @(posedge CLK_48MHZ or posedge RSTN) begin
        if (RSTN)
            par_q <= 1'b0;
        else
            par_q <= par_set | (par_q & ~ERR_CLR);
    end

    assign PAR_ERR = par_q;
`else
    assign PAR_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_lane_merge_rx.sv
// Directed bench for lane_merge_rx: a scoreboard queue is filled as words are driven and emptied on each accepted byte.
module tb_lane_merge_rx;

    localparam int DATA_W     = 8;
    localparam int ADDR_W     = 10;
    localparam int FIFO_DEPTH = 16;
`ifdef RX_PARITY_EN
    localparam int NB = DATA_W + 1;
    logic par_flip = 1'b0;
`else
    localparam int NB = DATA_W;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              valid = 1'b0;
    logic              din_a = 1'b0, din_b = 1'b0, din_c = 1'b0;
    logic [1:0]        mode = 2'b10;
    logic              err_clr = 1'b0;
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    logic              dvalid;
    logic              dready = 1'b1;
    logic              frame_err, ovf, par_err;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
    } exp_t;

    exp_t              sb[$];
    logic [ADDR_W-1:0] exp_addr = '0;
    int                total = 0;
    int                bad = 0;
    int                xfers = 0;
    int                mark;

    lane_merge_rx #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .CLK_48MHZ (clk),
        .RSTN      (rst),
        .VALID     (valid),
        .DIN_A     (din_a),
        .DIN_B     (din_b),
        .DIN_C     (din_c),
        .MODE      (mode),
        .ERR_CLR   (err_clr),
        .DATA      (data),
        .ADDR      (addr),
        .DATA_VALID(dvalid),
        .DATA_READY(dready),
        .FRAME_ERR (frame_err),
        .OVF       (ovf),
        .PAR_ERR   (par_err)
    );

    always #10 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Bytes beyond FIFO capacity while the sink stalls are dropped and never get an address
    task automatic push_expected(input logic [DATA_W-1:0] d);
        if (!dready && sb.size() >= FIFO_DEPTH)
            return;
        sb.push_back({d, exp_addr});
        exp_addr++;
    endtask

    task automatic apply_stimulus(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                  input logic [DATA_W-1:0] c, input logic [1:0] m);
        logic [NB-1:0] wa, wb, wc;
`ifdef RX_PARITY_EN
        wa = {a, (^a) ^ par_flip};
        wb = {b, ^b};
        wc = {c, ^c};
`else
        wa = a;
        wb = b;
        wc = c;
`endif
        for (int i = NB - 1; i >= 0; i--) begin
            valid = 1'b1;
            mode  = m;
            din_a = wa[i];
            din_b = wb[i];
            din_c = wc[i];
            @(posedge clk);
            #1;
        end
        push_expected(a);
        if (m != 2'b00) push_expected(b);
        if (m[1])       push_expected(c);
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        valid = 1'b0;
        err_clr = 1'b0;
        #1;
        check_output("rst_dvalid", 32'(dvalid), 32'd0);
        check_output("rst_data", 32'(data), 32'd0);
        check_output("rst_addr", 32'(addr), 32'd0);
        check_output("rst_flags", 32'({frame_err, ovf, par_err}), 32'd0);
        sb.delete();
        exp_addr = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((sb.size() != 0 || dvalid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_output(tag, 32'(n < 300), 32'd1);
    endtask

    task automatic pulse_err_clr();
        @(posedge clk);
        #1 err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        @(negedge clk);
    endtask

    // Every accepted byte must match the oldest scoreboard entry in data and address
    always @(negedge clk) begin
        exp_t e;
        if (!rst && dvalid && dready) begin
            xfers++;
            check_output("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check_output("out_data", 32'(data), 32'(e.data));
                check_output("out_addr", 32'(addr), 32'(e.addr));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Basic three-lane word with exact latency of each byte
        do_reset();
        dready = 1'b1;
        apply_stimulus(8'hA5, 8'h3C, 8'hFF, 2'b10);
        valid = 1'b0;
        @(negedge clk);
        check_output("lat_before", 32'(dvalid), 32'd0);
        @(negedge clk);
        check_output("lat_a_valid", 32'(dvalid), 32'd1);
        check_output("lat_a", 32'({addr, data}), 32'({10'd0, 8'hA5}));
        @(negedge clk);
        check_output("lat_b", 32'({addr, data}), 32'({10'd1, 8'h3C}));
        @(negedge clk);
        check_output("lat_c", 32'({addr, data}), 32'({10'd2, 8'hFF}));
        wait_drain("drain_t1");

        // Lane A only, back-to-back words, B/C toggling
        do_reset();
        mark = xfers;
        for (int w = 1; w <= 4; w++)
            apply_stimulus(DATA_W'(w), DATA_W'($urandom), DATA_W'($urandom), 2'b00);
        valid = 1'b0;
        wait_drain("drain_t2");
        check_output("t2_count", 32'(xfers - mark), 32'd4);
        check_output("t2_flags", 32'({frame_err, ovf, par_err}), 32'd0);

        // Sink stalled: 18 bytes into a 16-deep FIFO
        dready = 1'b0;
        do_reset();
        for (int w = 0; w < 6; w++)
            apply_stimulus(DATA_W'(w * 16 + 1), DATA_W'(w * 16 + 2), DATA_W'(w * 16 + 3), 2'b10);
        valid = 1'b0;
        repeat (5) @(negedge clk);
        check_output("ovf_set", 32'(ovf), 32'd1);
        check_output("ovf_head", 32'({dvalid, addr, data}), 32'({1'b1, 10'd0, 8'h01}));
        pulse_err_clr();
        check_output("ovf_clear", 32'(ovf), 32'd0);
        mark = xfers;
        dready = 1'b1;
        wait_drain("drain_t3");
        check_output("ovf_drain_count", 32'(xfers - mark), 32'd16);

        // Frame aborted after 5 bits, then a clean word
        do_reset();
        mark = xfers;
        for (int i = 0; i < 5; i++) begin
            valid = 1'b1;
            mode  = 2'b00;
            din_a = 1'($urandom);
            @(posedge clk);
            #1;
        end
        valid = 1'b0;
        @(posedge clk);
        #1;
        apply_stimulus(8'h55, 8'h00, 8'h00, 2'b00);
        valid = 1'b0;
        wait_drain("drain_t4");
        check_output("frame_err_set", 32'(frame_err), 32'd1);
        check_output("t4_count", 32'(xfers - mark), 32'd1);
        pulse_err_clr();
        check_output("frame_err_clear", 32'(frame_err), 32'd0);

        // Address wrap: 1023 bytes, then two more
        do_reset();
        for (int w = 0; w < 341; w++)
            apply_stimulus(DATA_W'(w), DATA_W'(w + 85), DATA_W'(w + 170), 2'b10);
        valid = 1'b0;
        @(posedge clk);
        #1;
        wait_drain("drain_t5a");
        check_output("addr_preload", 32'(addr), 32'd1023);
        apply_stimulus(8'hC3, 8'h3C, 8'h00, 2'b01);
        valid = 1'b0;
        wait_drain("drain_t5b");
        check_output("addr_wrapped", 32'(addr), 32'd1);

        // Reset mid-word discards the partial word
        mark = xfers;
        for (int i = 0; i < 4; i++) begin
            valid = 1'b1;
            mode  = 2'b10;
            din_a = 1'b1;
            @(posedge clk);
            #1;
        end
        do_reset();
        repeat (20) @(negedge clk);
        check_output("rst_mid_word_count", 32'(xfers - mark), 32'd0);

`ifdef RX_PARITY_EN
        // Bad parity still stores the byte
        do_reset();
        par_flip = 1'b1;
        apply_stimulus(8'h80, 8'h00, 8'h00, 2'b00);
        par_flip = 1'b0;
        valid = 1'b0;
        wait_drain("drain_par");
        check_output("par_err_set", 32'(par_err), 32'd1);
`else
        check_output("par_err_off", 32'(par_err), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
